// File: rtl/mbinit_pkg.sv
// -----------------------------------------------------------------------------
// mbinit_pkg
// Shared definitions for the MBINIT substate sequencer:
//   - substate index constants, in the order the sequencer runs them
//   - sequencer state encoding
//   - default sideband message code width
// -----------------------------------------------------------------------------
package mbinit_pkg;

  localparam int MBINIT_MSG_W = 4;

  localparam logic [2:0] SUB_PARAM      = 3'd0;
  localparam logic [2:0] SUB_CAL        = 3'd1;
  localparam logic [2:0] SUB_REPAIRCLK  = 3'd2;
  localparam logic [2:0] SUB_REPAIRVAL  = 3'd3;
  localparam logic [2:0] SUB_REVERSALMB = 3'd4;
  localparam logic [2:0] SUB_REPAIRMB   = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } mbinit_state_e;

endpackage

// File: rtl/mbinit_timeout_counter.sv
// -----------------------------------------------------------------------------
// mbinit_timeout_counter
// Per-substate watchdog. Counts enabled cycles and saturates at TO_CYCLES-1;
// o_expired is high while the count sits at that terminal value.
// Ports:
//   CLK        clock, posedge
//   rst_n      synchronous active-low reset
//   i_clear    synchronous clear (wins over i_enable)
//   i_enable   count this cycle
//   o_expired  terminal count reached
// -----------------------------------------------------------------------------
module mbinit_timeout_counter #(
  parameter int              TO_W      = 24,
  parameter logic [TO_W-1:0] TO_CYCLES = 24'd8000000
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TO_W-1:0] TERM = TO_CYCLES - TO_W'(1);

  logic [TO_W-1:0] r_cnt;
  logic            w_expired;

  assign w_expired = (r_cnt == TERM);
  assign o_expired = w_expired;

  // Saturating cycle counter with synchronous clear.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_cnt <= {TO_W{1'b0}};
    end else if (i_clear) begin
      r_cnt <= {TO_W{1'b0}};
    end else if (i_enable && !w_expired) begin
      r_cnt <= r_cnt + TO_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/mbinit_substate_sequencer.sv
// -----------------------------------------------------------------------------
// mbinit_substate_sequencer
// Runs the MBINIT substates in order (PARAM .. REPAIRMB), gives the active
// substate exclusive use of the sideband TX channel, merges error requests,
// applies a per-substate timeout and reports completion/error to the LTSM.
// Ports:
//   CLK, rst_n          clock / synchronous active-low reset
//   i_MBINIT_en         level: run MBINIT; low aborts to IDLE
//   i_sub_end           per-substate Module_end
//   i_sub_error_req     per-substate train_error_req
//   i_sub_tx_msg        per-substate TX code, sub k at [k*MSG_W +: MSG_W]
//   i_sub_tx_valid      per-substate TX valid
//   o_sub_en            cumulative enable (bit k high while k <= active idx)
//   o_sub_id            active substate index
//   o_TX_SbMessage      muxed TX code of active substate
//   o_ValidOutDatat     muxed TX valid of active substate
//   o_MBINIT_end        MBINIT complete
//   o_train_error_req   request TRAINERROR
//   o_timeout           error was caused by timeout (sticky until en drops)
// All outputs are registered from next state / next index.
// -----------------------------------------------------------------------------
module mbinit_substate_sequencer
  import mbinit_pkg::*;
#(
  parameter int              N_SUB     = 6,
  parameter int              MSG_W     = MBINIT_MSG_W,
  parameter int              TO_W      = 24,
  parameter logic [TO_W-1:0] TO_CYCLES = 24'd8000000
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic                   i_MBINIT_en,
  input  logic [N_SUB-1:0]       i_sub_end,
  input  logic [N_SUB-1:0]       i_sub_error_req,
  input  logic [N_SUB*MSG_W-1:0] i_sub_tx_msg,
  input  logic [N_SUB-1:0]       i_sub_tx_valid,
  output logic [N_SUB-1:0]       o_sub_en,
  output logic [2:0]             o_sub_id,
  output logic [MSG_W-1:0]       o_TX_SbMessage,
  output logic                   o_ValidOutDatat,
  output logic                   o_MBINIT_end,
  output logic                   o_train_error_req,
  output logic                   o_timeout
);

  localparam logic [2:0] LAST_IDX = 3'(N_SUB - 1);

  mbinit_state_e    r_state, w_state_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic             w_advance;
  logic             w_to_hit;
  logic             w_expired;
  logic             w_cnt_clear;
  logic             w_cnt_enable;
  logic             w_timeout_nxt;
  logic [N_SUB-1:0] w_sub_en_nxt;
  logic [MSG_W-1:0] w_tx_msg_nxt;
  logic             w_tx_valid_nxt;

  logic [N_SUB-1:0] r_sub_en;
  logic [2:0]       r_sub_id;
  logic [MSG_W-1:0] r_tx_msg;
  logic             r_tx_valid;
  logic             r_mbinit_end;
  logic             r_train_err;
  logic             r_timeout;

  // Counter restarts on entry to RUN, on every index advance and on leaving RUN.
  assign w_cnt_clear  = (r_state != RUN) || (w_state_nxt != RUN) || w_advance;
  assign w_cnt_enable = (r_state == RUN);

  mbinit_timeout_counter #(
    .TO_W      (TO_W),
    .TO_CYCLES (TO_CYCLES)
  ) u_timeout (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_enable),
    .o_expired (w_expired)
  );

  // Next state / next index. Only the active substate's end/error are looked at;
  // error beats end, end beats timeout, and a dropped enable beats everything.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_advance   = 1'b0;
    w_to_hit    = 1'b0;
    if (!i_MBINIT_en) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = SUB_PARAM;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = RUN;
          w_idx_nxt   = SUB_PARAM;
        end
        RUN: begin
          if (i_sub_error_req[r_idx]) begin
            w_state_nxt = ERROR;
          end else if (i_sub_end[r_idx]) begin
            if (r_idx < LAST_IDX) begin
              w_idx_nxt = r_idx + 3'd1;
              w_advance = 1'b1;
            end else begin
              w_state_nxt = DONE;
            end
          end else if (w_expired) begin
            w_state_nxt = ERROR;
            w_to_hit    = 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
        end
        DONE:    w_state_nxt = DONE;
        ERROR:   w_state_nxt = ERROR;
        default: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = SUB_PARAM;
        end
      endcase
    end
  end

  // Output decode from the next state, so outputs move on the same edge as the state.
  always_comb begin
    w_sub_en_nxt   = {N_SUB{1'b0}};
    w_tx_msg_nxt   = {MSG_W{1'b0}};
    w_tx_valid_nxt = 1'b0;
    case (w_state_nxt)
      RUN: begin
        for (int k = 0; k < N_SUB; k++) begin
          w_sub_en_nxt[k] = (3'(k) <= w_idx_nxt);
        end
        w_tx_msg_nxt   = i_sub_tx_msg[int'(w_idx_nxt)*MSG_W +: MSG_W];
        w_tx_valid_nxt = i_sub_tx_valid[w_idx_nxt];
      end
      DONE:    w_sub_en_nxt = {N_SUB{1'b1}};
      default: w_sub_en_nxt = {N_SUB{1'b0}};
    endcase
  end

  // Sticky timeout flag, dropped only when MBINIT is disabled.
  always_comb begin
    if (!i_MBINIT_en) begin
      w_timeout_nxt = 1'b0;
    end else if (w_to_hit) begin
      w_timeout_nxt = 1'b1;
    end else begin
      w_timeout_nxt = r_timeout;
    end
  end

  // State, index and output registers.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= SUB_PARAM;
      r_sub_en     <= {N_SUB{1'b0}};
      r_sub_id     <= 3'd0;
      r_tx_msg     <= {MSG_W{1'b0}};
      r_tx_valid   <= 1'b0;
      r_mbinit_end <= 1'b0;
      r_train_err  <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_sub_en     <= w_sub_en_nxt;
      r_sub_id     <= (w_state_nxt == RUN) ? w_idx_nxt : 3'd0;
      r_tx_msg     <= w_tx_msg_nxt;
      r_tx_valid   <= w_tx_valid_nxt;
      r_mbinit_end <= (w_state_nxt == DONE);
      r_train_err  <= (w_state_nxt == ERROR);
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign o_sub_en          = r_sub_en;
  assign o_sub_id          = r_sub_id;
  assign o_TX_SbMessage    = r_tx_msg;
  assign o_ValidOutDatat   = r_tx_valid;
  assign o_MBINIT_end      = r_mbinit_end;
  assign o_train_error_req = r_train_err;
  assign o_timeout         = r_timeout;

endmodule

// File: tb/tb_mbinit_substate_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mbinit_substate_sequencer
// Directed bench for the MBINIT substate sequencer (TO_CYCLES reduced to 16).
// Inputs change 1 time unit after a rising edge; outputs are read at that
// point, i.e. they show the effect of the edge just taken.
// -----------------------------------------------------------------------------
module tb_mbinit_substate_sequencer;

  localparam int N_SUB = 6;
  localparam int MSG_W = 4;

  logic                   CLK;
  logic                   rst_n;
  logic                   i_MBINIT_en;
  logic [N_SUB-1:0]       i_sub_end;
  logic [N_SUB-1:0]       i_sub_error_req;
  logic [N_SUB*MSG_W-1:0] i_sub_tx_msg;
  logic [N_SUB-1:0]       i_sub_tx_valid;
  logic [N_SUB-1:0]       o_sub_en;
  logic [2:0]             o_sub_id;
  logic [MSG_W-1:0]       o_TX_SbMessage;
  logic                   o_ValidOutDatat;
  logic                   o_MBINIT_end;
  logic                   o_train_error_req;
  logic                   o_timeout;

  int n_total;
  int n_bad;

  mbinit_substate_sequencer #(
    .N_SUB     (N_SUB),
    .MSG_W     (MSG_W),
    .TO_W      (24),
    .TO_CYCLES (24'd16)
  ) dut (
    .CLK               (CLK),
    .rst_n             (rst_n),
    .i_MBINIT_en       (i_MBINIT_en),
    .i_sub_end         (i_sub_end),
    .i_sub_error_req   (i_sub_error_req),
    .i_sub_tx_msg      (i_sub_tx_msg),
    .i_sub_tx_valid    (i_sub_tx_valid),
    .o_sub_en          (o_sub_en),
    .o_sub_id          (o_sub_id),
    .o_TX_SbMessage    (o_TX_SbMessage),
    .o_ValidOutDatat   (o_ValidOutDatat),
    .o_MBINIT_end      (o_MBINIT_end),
    .o_train_error_req (o_train_error_req),
    .o_timeout         (o_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Check the whole output set against expected values.
  task automatic chk_all(input string tag, input logic [5:0] en, input logic [2:0] id,
                         input logic done, input logic err, input logic to);
    chk({tag, ".sub_en"}, 32'(o_sub_en), 32'(en));
    chk({tag, ".sub_id"}, 32'(o_sub_id), 32'(id));
    chk({tag, ".end"},    32'(o_MBINIT_end), 32'(done));
    chk({tag, ".err"},    32'(o_train_error_req), 32'(err));
    chk({tag, ".to"},     32'(o_timeout), 32'(to));
  endtask

  // From IDLE with en high: enter RUN and walk up to substate 'target'.
  task automatic go_to_idx(input int target);
    i_MBINIT_en = 1'b1;
    i_sub_end   = 6'b000000;
    tick();
    for (int k = 0; k < target; k++) begin
      i_sub_end = 6'b000001 << k;
      tick();
    end
    i_sub_end = 6'b000000;
  endtask

  logic [5:0] masks [0:5];

  initial begin
    n_total = 0;
    n_bad   = 0;
    masks[0] = 6'b000001; masks[1] = 6'b000011; masks[2] = 6'b000111;
    masks[3] = 6'b001111; masks[4] = 6'b011111; masks[5] = 6'b111111;

    rst_n = 1'b0; i_MBINIT_en = 1'b0; i_sub_end = '0; i_sub_error_req = '0;
    i_sub_tx_msg = '0; i_sub_tx_valid = '0;
    tick(); tick();
    chk_all("reset", 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.valid", 32'(o_ValidOutDatat), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_all("idle_en0", 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0);

    // 1: full sequence, each end 10 cycles after its enable; ends stay latched.
    i_MBINIT_en = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      chk_all($sformatf("seq.enter%0d", k), masks[k], 3'(k), 1'b0, 1'b0, 1'b0);
      repeat (9) tick();
      chk($sformatf("seq.hold%0d", k), 32'(o_sub_en), 32'(masks[k]));
      i_sub_end[k] = 1'b1;
      tick();
    end
    chk("seq.done_end", 32'(o_MBINIT_end), 32'd1);
    chk("seq.done_en",  32'(o_sub_en), 32'h3f);
    chk("seq.done_err", 32'(o_train_error_req), 32'd0);
    tick();
    chk("seq.done_hold", 32'(o_MBINIT_end), 32'd1);

    // 6: synchronous reset during DONE.
    rst_n = 1'b0;
    #3;
    chk("srst.between_edges", 32'(o_MBINIT_end), 32'd1);
    tick();
    chk_all("srst.edge", 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; i_MBINIT_en = 1'b0; i_sub_end = '0;
    tick();

    // 5: abort at idx 3, then restart.
    go_to_idx(3);
    chk_all("abort.at3", 6'b001111, 3'd3, 1'b0, 1'b0, 1'b0);
    i_MBINIT_en = 1'b0;
    tick();
    chk_all("abort.idle", 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0);
    i_MBINIT_en = 1'b1;
    tick();
    chk_all("abort.restart", 6'b000001, 3'd0, 1'b0, 1'b0, 1'b0);
    i_MBINIT_en = 1'b0;
    tick();

    // 2: sideband mux at idx 4; sub2 traffic must not leak.
    go_to_idx(4);
    chk("mux.at4", 32'(o_sub_id), 32'd4);
    i_sub_tx_msg[4*MSG_W +: MSG_W] = 4'b0001; i_sub_tx_valid[4] = 1'b1;
    i_sub_tx_msg[2*MSG_W +: MSG_W] = 4'b0111; i_sub_tx_valid[2] = 1'b1;
    chk("mux.latency_valid", 32'(o_ValidOutDatat), 32'd0);
    tick();
    chk("mux.msg",   32'(o_TX_SbMessage), 32'h1);
    chk("mux.valid", 32'(o_ValidOutDatat), 32'd1);
    i_sub_tx_msg[4*MSG_W +: MSG_W] = 4'b0000; i_sub_tx_valid[4] = 1'b0;
    tick();
    chk("mux.sub2_msg",   32'(o_TX_SbMessage), 32'h0);
    chk("mux.sub2_valid", 32'(o_ValidOutDatat), 32'd0);

    // 3: error and end together on the active sub -> error wins.
    i_sub_error_req[4] = 1'b1; i_sub_end[4] = 1'b1;
    tick();
    chk_all("err.both", 6'b000000, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("err.valid_forced", 32'(o_ValidOutDatat), 32'd0);
    i_MBINIT_en = 1'b0;
    tick();
    chk_all("err.idle", 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0);
    i_sub_error_req = '0; i_sub_end = '0; i_sub_tx_msg = '0; i_sub_tx_valid = '0;

    // 4a: timeout in idx 1 after 16 RUN cycles.
    go_to_idx(1);
    repeat (15) tick();
    chk_all("to.cycle15", 6'b000011, 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("to.cycle16", 6'b000000, 3'd0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("to.sticky", 32'(o_timeout), 32'd1);
    i_MBINIT_en = 1'b0;
    tick();
    chk_all("to.cleared", 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0);

    // 4b: end on the terminal-count edge -> advance, no error.
    go_to_idx(1);
    repeat (15) tick();
    i_sub_end = 6'b000010;
    tick();
    chk_all("to.end_wins", 6'b000111, 3'd2, 1'b0, 1'b0, 1'b0);
    i_sub_end = '0;
    tick();
    chk("to.after_adv", 32'(o_train_error_req), 32'd0);
    i_MBINIT_en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
